// File: rtl/vdp_pkg.sv
// Shared VDP definitions.
// Register-file geometry and the copper op encodings used by vdp_copper and
// the register write port.
package vdp_pkg;

  localparam int unsigned VDP_REG_ADDR_W = 6;
  localparam int unsigned VDP_REG_DATA_W = 16;

  typedef enum logic [1:0] {
    CopOpMove = 2'd0,
    CopOpWait = 2'd1,
    CopOpSkip = 2'd2,
    CopOpEnd  = 2'd3
  } copper_op_e;

endpackage

// File: rtl/vdp_reg_write_port_if.sv
// Register write port bus bundle.
// Carries the copper write stream, the host write handshake, the register file
// write port and the debug status (overflow, fifo_level).
//   master: copper/host side plus register file/debug observer.
//   slave : vdp_reg_write_port.
interface vdp_reg_write_port_if
  import vdp_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = VDP_REG_ADDR_W,
  parameter int unsigned DATA_W = VDP_REG_DATA_W
);
  localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  copper_write_address;
  logic [DATA_W-1:0]  copper_write_data;
  logic               copper_write_en;
  logic               copper_write_ready;
  logic [ADDR_W-1:0]  host_write_address;
  logic [DATA_W-1:0]  host_write_data;
  logic               host_write_en;
  logic               host_write_ready;
  logic [ADDR_W-1:0]  reg_address;
  logic [DATA_W-1:0]  reg_data;
  logic               reg_write_en;
  logic               overflow;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output copper_write_address, copper_write_data, copper_write_en,
    output host_write_address, host_write_data, host_write_en,
    input  copper_write_ready, host_write_ready,
    input  reg_address, reg_data, reg_write_en, overflow, fifo_level
  );

  modport slave (
    input  copper_write_address, copper_write_data, copper_write_en,
    input  host_write_address, host_write_data, host_write_en,
    output copper_write_ready, host_write_ready,
    output reg_address, reg_data, reg_write_en, overflow, fifo_level
  );

endinterface

// File: rtl/vdp_reg_write_fifo.sv
// Copper write FIFO.
// Synchronous FIFO of DEPTH entries (power of two). A push while full is only
// accepted when a pop happens in the same cycle.
//   clk, reset : clock, synchronous active-high reset (flushes contents)
//   push       : write push_data (ignored when full and not popping)
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest entry
//   count      : entries held, 0..DEPTH
//   full/empty : status
module vdp_reg_write_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 22,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   push_data,
  output logic [WIDTH-1:0]   head,
  output logic [LEVEL_W-1:0] count,
  output logic               full,
  output logic               empty
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0] count_d, count_q;
  logic               push_ok, pop_ok;

  always_comb begin
    full    = (count_q == LEVEL_W'(DEPTH));
    empty   = (count_q == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/vdp_reg_write_port.sv
// VDP register write port.
// Serializes buffered copper writes and handshaked host writes onto the single
// register file write port. Copper wins unless the host has waited through
// STARVE_LIMIT copper commits, in which case the host takes the next slot.
//   clk, reset : clock, synchronous active-high reset
//   bus        : copper stream, host handshake, registered register file
//                write port, sticky overflow and fifo_level debug
module vdp_reg_write_port
  import vdp_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ADDR_W       = VDP_REG_ADDR_W,
  parameter int unsigned DATA_W       = VDP_REG_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  vdp_reg_write_port_if.slave bus
);

  localparam int unsigned LEVEL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W  = ADDR_W + DATA_W;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_LIMIT);
  // Ready leaves one entry of margin for a writer that strobes a cycle late.
  localparam logic [LEVEL_W-1:0]  ReadyMax  = LEVEL_W'(DEPTH - 2);

  logic [ENTRY_W-1:0]  fifo_head;
  logic [LEVEL_W-1:0]  fifo_count;
  logic                fifo_full, fifo_empty;
  logic                host_forced, grant_fifo, grant_host;
  logic [STARVE_W-1:0] starve_d, starve_q;
  logic                reg_we_d, reg_we_q;
  logic [ADDR_W-1:0]   reg_addr_d, reg_addr_q;
  logic [DATA_W-1:0]   reg_data_d, reg_data_q;
  logic                overflow_d, overflow_q;

  vdp_reg_write_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.copper_write_en),
    .pop      (grant_fifo),
    .push_data({bus.copper_write_address, bus.copper_write_data}),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    host_forced = (starve_q == StarveMax) && bus.host_write_en;
    grant_fifo  = !reset && !fifo_empty && !host_forced;
    grant_host  = !reset && !grant_fifo && bus.host_write_en;

    starve_d = starve_q;
    if (!bus.host_write_en || grant_host) begin
      starve_d = '0;
    end else if (grant_fifo && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end

    reg_we_d   = grant_fifo || grant_host;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    if (grant_fifo) begin
      {reg_addr_d, reg_data_d} = fifo_head;
    end else if (grant_host) begin
      reg_addr_d = bus.host_write_address;
      reg_data_d = bus.host_write_data;
    end

    // A push into a full FIFO survives only if the head leaves this cycle.
    overflow_d = overflow_q || (bus.copper_write_en && fifo_full && !grant_fifo);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= '0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.host_write_ready   = grant_host;
  assign bus.copper_write_ready = (fifo_count <= ReadyMax);
  assign bus.reg_write_en       = reg_we_q;
  assign bus.reg_address        = reg_addr_q;
  assign bus.reg_data           = reg_data_q;
  assign bus.overflow           = overflow_q;
  assign bus.fifo_level         = fifo_count;

endmodule

// File: tb/tb_vdp_reg_write_port.sv
// Bench for vdp_reg_write_port: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vdp_reg_write_port;

  localparam int DEPTH = 4;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vdp_reg_write_port_if #(.DEPTH(DEPTH), .ADDR_W(6), .DATA_W(16)) bus ();

  vdp_reg_write_port #(
    .DEPTH(DEPTH),
    .ADDR_W(6),
    .DATA_W(16),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending copper writes, host wait count.
  logic [21:0] m_q[$];
  int          m_starve = 0;
  bit          m_ovf = 0;
  bit          m_we = 0;
  logic [5:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  bit          model_valid = 0;

  task automatic model_step();
    bit take_copper, take_host;
    if (reset) begin
      m_q.delete();
      m_starve = 0;
      m_ovf = 0;
      m_we = 0;
      m_addr = '0;
      m_data = '0;
      model_valid = 1;
      return;
    end
    take_copper = (m_q.size() != 0) && !(m_starve == LIMIT && bus.host_write_en);
    take_host = !take_copper && bus.host_write_en;
    m_we = take_copper || take_host;
    if (take_copper) begin
      {m_addr, m_data} = m_q.pop_front();
    end else if (take_host) begin
      m_addr = bus.host_write_address;
      m_data = bus.host_write_data;
    end
    if (bus.copper_write_en) begin
      if (m_q.size() < DEPTH) m_q.push_back({bus.copper_write_address, bus.copper_write_data});
      else m_ovf = 1;
    end
    if (!bus.host_write_en || take_host) m_starve = 0;
    else if (take_copper && m_starve < LIMIT) m_starve++;
  endtask

  always @(posedge clk) model_step();

  logic [5:0] commit_log[$];
  int         max_level = 0;

  always @(negedge clk) begin
    if (model_valid) begin
      check("reg_write_en", bus.reg_write_en, m_we);
      if (m_we) begin
        check("reg_address", bus.reg_address, m_addr);
        check("reg_data", bus.reg_data, m_data);
      end
      check("overflow", bus.overflow, m_ovf);
      check("fifo_level", bus.fifo_level, m_q.size());
      check("copper_write_ready", bus.copper_write_ready, m_q.size() <= DEPTH - 2);
      check("host_write_ready", bus.host_write_ready,
            !reset && bus.host_write_en && (m_q.size() == 0 || m_starve == LIMIT));
      if (bus.reg_write_en) commit_log.push_back(bus.reg_address);
      if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic copper_burst(input int n, input logic [5:0] a0, input logic [15:0] d0);
    for (int i = 0; i < n; i++) begin
      bus.copper_write_en = 1'b1;
      bus.copper_write_address = a0 + 6'(i);
      bus.copper_write_data = d0 + 16'(i);
      tick();
    end
    bus.copper_write_en = 1'b0;
  endtask

  // Holds the request until accepted; leaves host_write_en high on return.
  task automatic host_write(input logic [5:0] a, input logic [15:0] d);
    bit ok = 0;
    bus.host_write_en = 1'b1;
    bus.host_write_address = a;
    bus.host_write_data = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.host_write_ready;
      tick();
    end
    if (!ok) check("host_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lvl;
    bit hit;
    bus.copper_write_en = 1'b0;
    bus.copper_write_address = '0;
    bus.copper_write_data = '0;
    bus.host_write_en = 1'b0;
    bus.host_write_address = '0;
    bus.host_write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_reg_write_en", bus.reg_write_en, 0);
    check("rst_reg_address", bus.reg_address, 0);
    check("rst_reg_data", bus.reg_data, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_fifo_level", bus.fifo_level, 0);
    check("rst_copper_ready", bus.copper_write_ready, 1);
    check("rst_host_ready", bus.host_write_ready, 0);

    // Single copper write: strobe in N, strobe out in N+2 only
    tick();
    bus.copper_write_en = 1'b1;
    bus.copper_write_address = 6'h05;
    bus.copper_write_data = 16'h1234;
    tick();
    bus.copper_write_en = 1'b0;
    @(negedge clk);
    check("cu_n1_we", bus.reg_write_en, 0);
    check("cu_n1_level", bus.fifo_level, 1);
    tick();
    @(negedge clk);
    check("cu_n2_we", bus.reg_write_en, 1);
    check("cu_n2_addr", bus.reg_address, 6'h05);
    check("cu_n2_data", bus.reg_data, 16'h1234);
    tick();
    @(negedge clk);
    check("cu_n3_we", bus.reg_write_en, 0);

    // Host write with empty FIFO
    tick();
    bus.host_write_en = 1'b1;
    bus.host_write_address = 6'h20;
    bus.host_write_data = 16'hBEEF;
    @(negedge clk);
    check("host_ready_same_cycle", bus.host_write_ready, 1);
    tick();
    bus.host_write_en = 1'b0;
    @(negedge clk);
    check("host_we", bus.reg_write_en, 1);
    check("host_addr", bus.reg_address, 6'h20);
    check("host_data", bus.reg_data, 16'hBEEF);
    check("host_ready_after", bus.host_write_ready, 0);
    tick();

    // Six back-to-back copper writes
    commit_log.delete();
    copper_burst(6, 6'h08, 16'hA000);
    repeat (4) tick();
    check("burst_count", commit_log.size(), 6);
    check("burst_first", commit_log[0], 6'h08);
    check("burst_last", commit_log[5], 6'h0D);
    check("burst_overflow", bus.overflow, 0);

    // Held host write behind continuous copper traffic
    commit_log.delete();
    fork
      copper_burst(8, 6'h10, 16'hC000);
      begin
        tick();
        host_write(6'h3F, 16'h7777);
        bus.host_write_en = 1'b0;
      end
    join
    repeat (4) tick();
    check("starve_count", commit_log.size(), 9);
    check("starve_copper4", commit_log[3], 6'h13);
    check("starve_host_slot", commit_log[4], 6'h3F);
    check("starve_copper5", commit_log[5], 6'h14);

    // Forced host slots stall pops until the FIFO overflows
    max_level = 0;
    fork
      copper_burst(40, 6'h00, 16'h1000);
      begin
        for (int i = 0; i < 12; i++) host_write(6'h30 + 6'(i), 16'hF000 + 16'(i));
        bus.host_write_en = 1'b0;
      end
    join
    repeat (6) tick();
    check("ovf_set", bus.overflow, 1);
    check("ovf_max_level", max_level, DEPTH);
    repeat (4) tick();
    check("ovf_sticky", bus.overflow, 1);

    // Reset with three entries queued and a host write pending
    bus.host_write_en = 1'b1;
    bus.host_write_address = 6'h2A;
    bus.host_write_data = 16'h5555;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      lvl = int'(bus.fifo_level);
      #1;
      if (lvl == 3) begin
        hit = 1;
        bus.copper_write_en = 1'b0;
        reset = 1'b1;
      end else begin
        bus.copper_write_en = 1'b1;
        bus.copper_write_address = 6'h20 + 6'(i);
        bus.copper_write_data = 16'h2000 + 16'(i);
      end
    end
    check("rst_mid_reached_3", hit, 1);
    #1;
    check("rst_mid_host_ready", bus.host_write_ready, 0);
    tick();
    tick();
    reset = 1'b0;
    bus.host_write_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_we", bus.reg_write_en, 0);
      check("rst_mid_level", bus.fifo_level, 0);
      check("rst_mid_overflow", bus.overflow, 0);
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vdp_reg_write_port.md
# vdp_reg_write_port

Register-write responder for the VDP: accepts raster-timed register writes from the copper and host (CPU bus) register writes, and serializes both onto the single write port of the VDP register file. Copper writes are buffered in a small FIFO and take priority, with a starvation guard so host writes always make progress. Sits between `vdp_copper`, the host bus decoder, and the VDP register file.

## Interface
Parameters:
- `DEPTH`, 4: copper FIFO entries; power of two, at least 4.
- `ADDR_W`, 6: register address width.
- `DATA_W`, 16: register data width.
- `STARVE_LIMIT`, 4: number of consecutive copper commits, while a host write waits, before the host is granted one slot.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `copper_write_address`, in, ADDR_W: copper target register.
- `copper_write_data`, in, DATA_W: copper write data.
- `copper_write_en`, in, 1: single-cycle strobe; always pushed, no hold.
- `copper_write_ready`, out, 1: high when the FIFO count is at most DEPTH-2.
- `host_write_address`, in, ADDR_W: host target register.
- `host_write_data`, in, DATA_W: host write data.
- `host_write_en`, in, 1: held high, with address and data stable, until accepted.
- `host_write_ready`, out, 1: host write accepted this cycle when high together with `host_write_en`.
- `reg_address`, out, ADDR_W: register file address. Registered.
- `reg_data`, out, DATA_W: register file data. Registered.
- `reg_write_en`, out, 1: register file write strobe. Registered.
- `overflow`, out, 1: sticky; a copper write was dropped.
- `fifo_level`, out, clog2(DEPTH)+1: current FIFO count, for debug.

## Operation
- Copper push happens on `copper_write_en`.
  - If the FIFO is full and not popping this cycle, the write is dropped and `overflow` is set. `overflow` clears only on reset.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted and the count is unchanged.
- Commit arbiter: at most one commit per cycle.
  - Grant FIFO head if the FIFO is non-empty and not host-forced.
  - Otherwise grant the host if `host_write_en` is high.
  - Host-forced: `starve_cnt == STARVE_LIMIT` and `host_write_en` is high.
- `host_write_ready` is combinational: `host_write_en` && (FIFO empty || host-forced).
- Starvation counter `starve_cnt`:
  - Increments on each FIFO commit while `host_write_en` is high, saturating at STARVE_LIMIT.
  - Clears on a host commit or when `host_write_en` is low.
- A copper push in the same cycle does not make the FIFO non-empty for arbitration until the next cycle.
- Order: copper writes commit in FIFO order. Host and copper order is defined only by the arbiter.
- Reset mid-operation:
  - FIFO is flushed; entries are discarded, not committed.
  - Any pending host write is not accepted in the reset cycle.

## Timing
- Reset values:
  - `reg_write_en` = 0, `reg_address` = 0, `reg_data` = 0.
  - `overflow` = 0, `fifo_level` = 0.
  - `copper_write_ready` = 1, `host_write_ready` = 0, `starve_cnt` = 0.
- Copper latency: strobe in cycle N → FIFO head in cycle N+1 → `reg_write_en` high in cycle N+2 if granted in N+1.
- Host latency: accepted in cycle N → `reg_write_en` high in cycle N+1.
- `reg_write_en` is high for exactly one cycle per commit. Back-to-back commits produce back-to-back strobes.
- `copper_write_ready` has one cycle of margin: a writer that samples ready and strobes one cycle later never overflows.
- Sustained throughput is one write per clock. Under continuous copper traffic the host gets at least 1 slot per STARVE_LIMIT+1 cycles.
- Pointers wrap modulo DEPTH. `fifo_level` ranges 0..DEPTH.

## Structure
- Shared package `vdp_pkg`:
  - `VDP_REG_ADDR_W` = 6, `VDP_REG_DATA_W` = 16.
  - Copper op encodings, shared with `vdp_copper`.
- One sub-module, `vdp_reg_write_fifo`:
  - Synchronous FIFO with push, pop, head, count, full, empty.
  - Supports same-cycle push and pop at full.
- Arbiter, starvation counter and output register stay in the top module.

## Test plan
- After reset: single copper strobe, addr 0x05, data 0x1234, in cycle 10 → `reg_write_en` in cycle 12 only, `reg_address` = 0x05, `reg_data` = 0x1234.
- Host write held, addr 0x20, data 0xBEEF, FIFO empty → ready in the same cycle, commit in the next cycle, `host_write_ready` low afterwards.
- 6 consecutive copper strobes with DEPTH = 4 and no host traffic → all 6 commit in order, `overflow` = 0, `copper_write_ready` deasserts while the count is above 2.
- Continuous copper strobes plus a held host write → the host commits after exactly 4 copper commits; copper order is preserved.
- Force pops off (host-forced path), fill 4 entries, then strobe a 5th → 5th write dropped, `overflow` = 1 until reset, `fifo_level` = 4.
- Assert reset with 3 entries queued → no further `reg_write_en`, `fifo_level` = 0, `overflow` = 0.
